rsa_modexp_scheduler: RTL
=========================

# rsa_modexp_scheduler

Sequencing and arbitration controller for the shared fast modular exponentiation engine in the RSA datapath. It holds the key configuration (modulus, public and private exponent) and accepts encrypt or decrypt jobs from two requesters under round-robin arbitration. Each accepted job is issued to the engine with a one-cycle start pulse, and the block waits for engine completion with a timeout. The result is returned to the originating requester over a valid/ready handshake.

## Interface
- N, 55, operand width: base, modulus, exponents, result
- TIMEOUT, 4096, max cycles waited for eng_done before aborting a job
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- cfg_we  in  1  config write strobe
- cfg_modulus  in  N  RSA modulus n
- cfg_e  in  N  public exponent
- cfg_d  in  N  private exponent
- req_valid  in  2  bit i: requester i has a job
- req_op  in  2  bit i: 0 = encrypt (use e), 1 = decrypt (use d)
- req_base0 / req_base1  in  N each  message or ciphertext of requester 0 / 1
- req_ready  out  2  one-hot acceptance; job taken when req_valid[i] & req_ready[i]
- rsp_valid  out  2  bit i: result pending for requester i
- rsp_ready  in  2  bit i: requester i consumes result
- rsp_data  out  N  result value, shared by both requesters
- rsp_err  out  1  qualifies rsp_data: 1 = job aborted (bad base or timeout)
- eng_st  out  1  engine start pulse
- eng_base, eng_exponent, eng_modulus  out  N each  engine operands, stable from the start pulse until eng_done
- eng_out  in  N  engine result
- eng_done  in  1  engine result valid, single-cycle pulse
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, START, WAIT, RESP.
- Reset: state IDLE, cfg_loaded=0, last_grant=1 (requester 0 wins first), all outputs 0.
- Config: cfg_we in IDLE latches n, e, d and sets cfg_loaded.
  - Ignored in any other state, and ignored if cfg_modulus < 2.
  - While cfg_we is high, req_ready=0, so a config write beats a request in the same cycle.
- Arbitration (IDLE, cfg_loaded=1, cfg_we=0): req_ready is combinational and one-hot.
  - Only one requester valid: grant it.
  - Both valid: grant the requester that is not last_grant.
  - No grant while cfg_loaded=0.
- On handshake, latch base, op and id (0/1). Exponent = d if op is 1, else e.
  - Base >= n: skip the engine and go to RESP with rsp_err=1, rsp_data=0.
  - Otherwise go to START.
- START: eng_st=1 for exactly one cycle, timer cleared, then go to WAIT.
- WAIT:
  - eng_done: capture eng_out into rsp_data, rsp_err=0, go to RESP.
  - Timer reaches TIMEOUT-1 without eng_done: rsp_data=0, rsp_err=1, go to RESP.
  - eng_done in the same cycle as the timeout: eng_done wins.
- RESP: rsp_valid[id]=1 and held, together with data and err, until rsp_ready[id].
  - Then last_grant=id and return to IDLE.
  - rsp_ready on the other bit is ignored.
- eng_done outside WAIT is ignored.
- Reset mid-job: immediate return to the reset state. The job is lost and config must be rewritten.

## Timing
- Handshake at edge k: START during k..k+1, eng_st high in that cycle.
- Engine done at edge m: rsp_valid is high from edge m+1.
- Minimum accept-to-response latency is 3 cycles with an immediate eng_done.
- Bad-base rejection responds 1 cycle after the handshake.
- Back-to-back jobs: after a consuming rsp_ready at edge r, IDLE can accept again at edge r+1.
- Timer width is clog2(TIMEOUT). The timer counts WAIT cycles only.

## Test plan
- Config n=3233, e=17, d=2753. Req0 encrypt base 65, engine model returns 2790 -> rsp_valid[0], rsp_data=2790, rsp_err=0, exactly one eng_st pulse with eng_exponent=17.
- Req1 decrypt base 2790 -> eng_exponent=2753, rsp_data=65 on rsp_valid[1]; rsp_valid[0] stays 0.
- Both req_valid held for 4 jobs from reset -> grant order 0,1,0,1; no second grant before the prior response is consumed.
- Req0 base 3233 (= n) -> no eng_st, rsp_err=1, rsp_data=0 one cycle after the handshake.
- TIMEOUT=16, engine never asserts eng_done -> rsp_err=1 after 16 WAIT cycles. A later eng_done in IDLE has no effect.
- Coverage of config and reset rules:
  - Requests before any config -> req_ready stays 0.
  - cfg_we during WAIT -> old n is kept.
  - cfg_we in the same IDLE cycle as req_valid -> no grant that cycle.
  - Reset asserted in WAIT -> all outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/rsa_modexp_scheduler.sv
// rsa_modexp_scheduler: holds the RSA key, arbitrates two requesters round-robin,
// drives the shared modexp engine with a start pulse and returns the result with
// a timeout guard.
module rsa_modexp_scheduler #(
    parameter int unsigned N       = 55,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_cfg_we,
    input  logic [N-1:0] i_cfg_modulus,
    input  logic [N-1:0] i_cfg_e,
    input  logic [N-1:0] i_cfg_d,
    input  logic [1:0]   i_req_valid,
    input  logic [1:0]   i_req_op,
    input  logic [N-1:0] i_req_base0,
    input  logic [N-1:0] i_req_base1,
    output logic [1:0]   o_req_ready,
    output logic [1:0]   o_rsp_valid,
    input  logic [1:0]   i_rsp_ready,
    output logic [N-1:0] o_rsp_data,
    output logic         o_rsp_err,
    output logic         o_eng_st,
    output logic [N-1:0] o_eng_base,
    output logic [N-1:0] o_eng_exponent,
    output logic [N-1:0] o_eng_modulus,
    input  logic [N-1:0] i_eng_out,
    input  logic         i_eng_done,
    output logic         o_busy
);

    localparam int unsigned  TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StWait, StResp} state_e;

    state_e        r_state;
    logic          r_cfg_loaded;
    logic          r_last_grant;
    logic          r_id;
    logic [N-1:0]  r_n;
    logic [N-1:0]  r_e;
    logic [N-1:0]  r_d;
    logic [TW-1:0] r_timer;
    logic [1:0]    r_rsp_valid;
    logic [N-1:0]  r_rsp_data;
    logic          r_rsp_err;
    logic          r_eng_st;
    logic [N-1:0]  r_eng_base;
    logic [N-1:0]  r_eng_exp;
    logic [N-1:0]  r_eng_mod;
    logic          r_busy;

    logic [1:0]    w_req_ready;
    logic          w_grant_id;
    logic          w_take;
    logic [N-1:0]  w_base;

    // Round-robin grant; a config write in the same cycle suppresses any grant.
    always_comb begin
        w_req_ready = 2'b00;
        w_grant_id  = 1'b0;
        if (r_state == StIdle && r_cfg_loaded && !i_cfg_we) begin
            case (i_req_valid)
                2'b01: begin
                    w_grant_id  = 1'b0;
                    w_req_ready = 2'b01;
                end
                2'b10: begin
                    w_grant_id  = 1'b1;
                    w_req_ready = 2'b10;
                end
                2'b11: begin
                    w_grant_id  = ~r_last_grant;
                    w_req_ready = {~r_last_grant, r_last_grant};
                end
                default: begin
                    w_grant_id  = 1'b0;
                    w_req_ready = 2'b00;
                end
            endcase
        end
    end

    assign w_take = |(w_req_ready & i_req_valid);
    assign w_base = w_grant_id ? i_req_base1 : i_req_base0;

    // Job sequencing FSM with registered outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_cfg_loaded <= 1'b0;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_n          <= '0;
            r_e          <= '0;
            r_d          <= '0;
            r_timer      <= '0;
            r_rsp_valid  <= 2'b00;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
            r_eng_st     <= 1'b0;
            r_eng_base   <= '0;
            r_eng_exp    <= '0;
            r_eng_mod    <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_eng_st <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_cfg_we) begin
                        if (i_cfg_modulus >= N'(2)) begin
                            r_n          <= i_cfg_modulus;
                            r_e          <= i_cfg_e;
                            r_d          <= i_cfg_d;
                            r_cfg_loaded <= 1'b1;
                        end
                    end else if (w_take) begin
                        r_id       <= w_grant_id;
                        r_eng_base <= w_base;
                        r_eng_exp  <= i_req_op[w_grant_id] ? r_d : r_e;
                        r_eng_mod  <= r_n;
                        r_busy     <= 1'b1;
                        if (w_base >= r_n) begin
                            // Base outside the residue range: reject without the engine.
                            r_rsp_data  <= '0;
                            r_rsp_err   <= 1'b1;
                            r_rsp_valid <= {w_grant_id, ~w_grant_id};
                            r_state     <= StResp;
                        end else begin
                            r_eng_st <= 1'b1;
                            r_state  <= StStart;
                        end
                    end
                end
                StStart: begin
                    r_timer <= '0;
                    r_state <= StWait;
                end
                StWait: begin
                    if (i_eng_done) begin
                        r_rsp_data  <= i_eng_out;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= {r_id, ~r_id};
                        r_state     <= StResp;
                    end else if (r_timer == TimerLast) begin
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= {r_id, ~r_id};
                        r_state     <= StResp;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                StResp: begin
                    if (i_rsp_ready[r_id]) begin
                        r_rsp_valid  <= 2'b00;
                        r_last_grant <= r_id;
                        r_busy       <= 1'b0;
                        r_state      <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_req_ready    = w_req_ready;
    assign o_rsp_valid    = r_rsp_valid;
    assign o_rsp_data     = r_rsp_data;
    assign o_rsp_err      = r_rsp_err;
    assign o_eng_st       = r_eng_st;
    assign o_eng_base     = r_eng_base;
    assign o_eng_exponent = r_eng_exp;
    assign o_eng_modulus  = r_eng_mod;
    assign o_busy         = r_busy;

endmodule
